// File: rtl/key_sched.sv
// -----------------------------------------------------------------------------
// key_sched -- iterative AES key expansion, one 128-bit round key per cycle.
//
// The block accepts a 128- or 256-bit cipher key and streams round keys
// 0..NR over a valid/ready handshake. A stalled consumer freezes all state.
// The S-box lives inside the block as a combinational table, so every accepted
// round key is followed by the next one on the very next cycle.
//
// Ports
//   clk       in   1         clock, all state changes on the rising edge
//   rst_n     in   1         asynchronous active-low reset
//   start     in   1         expand key_in (only looked at in IDLE)
//   key_in    in   KEY_BITS  cipher key, MSB is the first key byte
//   busy      out  1         high while a key is being streamed
//   rk_valid  out  1         rk_out / rk_index carry a round key
//   rk_ready  in   1         consumer takes the round key on valid && ready
//   rk_out    out  128       round key, w[4r] in bits [127:96]
//   rk_index  out  4         round number of rk_out, 0..NR
//   done      out  1         one-cycle pulse after round key NR is taken
// -----------------------------------------------------------------------------
module key_sched #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_out,
    output logic [3:0]          rk_index,
    output logic                done
);

    localparam int         NR     = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam bit         IS_256 = (KEY_BITS == 256);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon_byte(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] prev_q, prev_d;   // older half of the {prev, cur} window
    logic [127:0] cur_q, cur_d;     // round key currently presented
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    // ---------------------------------------------------------------------
    // Expansion datapath: derives round idx_q+1 from the window.
    // ---------------------------------------------------------------------
    logic [31:0]  last_word;
    logic [31:0]  rot_word;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  temp_word;
    logic [3:0]   rcon_idx;
    logic         no_rot;           // AES-256 odd round: SubWord only
    logic [127:0] base_key;
    logic [127:0] expanded;
    logic [127:0] next_rk;

    assign last_word = cur_q[31:0];
    assign rot_word  = {last_word[23:0], last_word[31:24]};

    // The next round r = idx_q + 1 is odd exactly when idx_q is even.
    assign no_rot   = IS_256 && !idx_q[0];
    assign sub_in   = no_rot ? last_word : rot_word;

    // For AES-256 the even round r uses Rcon[r/2-1] = Rcon[idx_q >> 1].
    assign rcon_idx = IS_256 ? {1'b0, idx_q[3:1]} : idx_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_out[8*gi +: 8] = SBOX[sub_in[8*gi +: 8]];
        end
    endgenerate

    assign temp_word = no_rot ? sub_out : (sub_out ^ {rcon_byte(rcon_idx), 24'h000000});

    // AES-128 chains off the current key, AES-256 off the key two rounds back.
    assign base_key = IS_256 ? prev_q : cur_q;

    assign expanded[127:96] = base_key[127:96] ^ temp_word;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_chain
            assign expanded[127-32*gi -: 32] = base_key[127-32*gi -: 32] ^ expanded[159-32*gi -: 32];
        end
    endgenerate

    // For AES-256 round 1 is simply the low key half, parked in prev at
    // load time; shifting the window then swaps the halves into order.
    assign next_rk = (IS_256 && (idx_q == 4'd0)) ? prev_q : expanded;

    // ---------------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cur_d   = key_in[KEY_BITS-1 -: 128];
                    prev_d  = IS_256 ? key_in[127:0] : 128'd0;
                    idx_d   = 4'd0;
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (idx_q == NR_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        prev_d = cur_q;
                        cur_d  = next_rk;
                        idx_d  = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= '0;
            cur_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign rk_valid = (state_q == RUN);
    assign rk_out   = cur_q;
    assign rk_index = idx_q;
    assign done     = done_q;

endmodule
